// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter onto one four-phase word interface, with watchdog reissue.
// Partial-store read-modify-write is built only when ARB_RMW_EN is defined.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETRY_GAP      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] addr,
  output logic [31:0] data_i,
  output logic        ren,
  output logic        wen,
  input  logic        ack,
  input  logic [31:0] data_o,
  output logic        timeout_seen
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RELEASE, RETRY} state_t;

  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(RETRY_GAP - 1);

  state_t     state;
  state_t     resume;
  logic       owner_d;
  logic       retry_wen;
  logic [7:0] wd_cnt;
  logic [7:0] gap_cnt;
  logic       busy;

  // Word addressing: the byte offset bits never reach the interpreter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign busy = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);

`ifdef ARB_RMW_EN
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        rmw_pend;
  logic [31:0] be_mask;
  logic [31:0] merged;

  always_comb begin
    be_mask = '0;
    for (int n = 0; n < 4; n++) be_mask[8*n +: 8] = {8{cap_be[n]}};
    merged = (data_o & ~be_mask) | (cap_wdata & be_mask);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      resume       <= IDLE;
      owner_d      <= 1'b0;
      retry_wen    <= 1'b0;
      wd_cnt       <= '0;
      gap_cnt      <= '0;
      addr         <= '0;
      data_i       <= '0;
      ren          <= 1'b0;
      wen          <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      timeout_seen <= 1'b0;
`ifdef ARB_RMW_EN
      cap_be       <= '0;
      cap_wdata    <= '0;
      rmw_pend     <= 1'b0;
`endif
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;

      // Watchdog: an unacked strobe is dropped after TIMEOUT_CYCLES high cycles.
      if (busy && !ack) begin
        if (wd_cnt == WD_LAST) begin
          ren          <= 1'b0;
          wen          <= 1'b0;
          retry_wen    <= wen;
          resume       <= state;
          gap_cnt      <= '0;
          timeout_seen <= 1'b1;
          state        <= RETRY;
        end else begin
          wd_cnt <= wd_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: if (!ack) begin
          if (d_req) begin
            owner_d <= 1'b1;
            addr    <= {d_addr[31:2], 2'b00};
            wd_cnt  <= '0;
            if (!d_we) begin
              ren   <= 1'b1;
              state <= RD;
            end else if (d_be == 4'h0) begin
              // Empty store: completes via RELEASE so the done cycle never meets IDLE.
              d_done <= 1'b1;
              state  <= RELEASE;
`ifdef ARB_RMW_EN
            end else if (d_be != 4'hF) begin
              ren       <= 1'b1;
              cap_be    <= d_be;
              cap_wdata <= d_wdata;
              state     <= RMW_RD;
`endif
            end else begin
              wen    <= 1'b1;
              data_i <= d_wdata;
              state  <= WR;
            end
          end else if (i_req) begin
            owner_d <= 1'b0;
            addr    <= {i_addr[31:2], 2'b00};
            wd_cnt  <= '0;
            ren     <= 1'b1;
            state   <= RD;
          end
        end
        RD: if (ack) begin
          ren <= 1'b0;
          if (owner_d) begin
            d_rdata <= data_o;
            d_done  <= 1'b1;
          end else begin
            i_rdata <= data_o;
            i_done  <= 1'b1;
          end
          state <= RELEASE;
        end
        WR: if (ack) begin
          wen    <= 1'b0;
          d_done <= 1'b1;
          state  <= RELEASE;
        end
`ifdef ARB_RMW_EN
        RMW_RD: if (ack) begin
          ren      <= 1'b0;
          data_i   <= merged;
          rmw_pend <= 1'b1;
          state    <= RELEASE;
        end
        RMW_WR: if (ack) begin
          wen    <= 1'b0;
          d_done <= 1'b1;
          state  <= RELEASE;
        end
`endif
        RELEASE: if (!ack) begin
`ifdef ARB_RMW_EN
          if (rmw_pend) begin
            rmw_pend <= 1'b0;
            wen      <= 1'b1;
            wd_cnt   <= '0;
            state    <= RMW_WR;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        RETRY: begin
          // A late ack restarts the gap so the reissue never overlaps it.
          if (ack) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            ren    <= ~retry_wen;
            wen    <= retry_wen;
            wd_cnt <= '0;
            state  <= resume;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: memory responder, reference memory model,
// per-cycle protocol compare process and a few literal directed expectations.
module tb_mem_port_arbiter;
  localparam int TO  = 8;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic        ren;
  logic        wen;
  logic        ack = 1'b0;
  logic [31:0] data_o = '0;
  logic        timeout_seen;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .RETRY_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .addr(addr), .data_i(data_i), .ren(ren), .wen(wen), .ack(ack), .data_o(data_o),
    .timeout_seen(timeout_seen)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [16];
  logic [31:0] refmem [16];
  acc_t log_q[$];
  bit no_ack = 1'b0;
  int lat_lo = 0;
  int lat_hi = 4;
  int d_done_cnt = 0, i_done_cnt = 0, stb_cnt = 0;
  int d_ops = 0, i_ops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old;
`ifdef ARB_RMW_EN
    for (int n = 0; n < 4; n++) if (be[n]) r[8*n +: 8] = wd[8*n +: 8];
`else
    if (be != 4'h0) r = wd;
`endif
    return r;
  endfunction

  // Interpreter stand-in: four-phase ack, memory indexed by word address bits [5:2].
  initial begin
    int lat, guard;
    bit aborted;
    logic [3:0] idx;
    forever begin
      @(posedge clk); #1;
      if (rst_n && (ren || wen) && !no_ack) begin
        lat = $urandom_range(lat_lo, lat_hi);
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
          if (!(ren || wen)) aborted = 1'b1;
        end
        if (!aborted && (ren || wen) && !no_ack) begin
          idx = addr[5:2];
          if (wen) begin
            mem[idx] = data_i;
            log_q.push_back({1'b1, addr, data_i});
          end else begin
            data_o = mem[idx];
            log_q.push_back({1'b0, addr, mem[idx]});
          end
          ack = 1'b1;
          guard = 0;
          while ((ren || wen) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
          end
          check("strobe_release", 32'(guard < 50), 1);
          ack = 1'b0;
          data_o = $urandom;
        end
      end
    end
  end

  // Per-cycle protocol compare against the interface rules.
  logic prev_stb = 1'b0, prev_ack = 1'b0, prev_id = 1'b0, prev_dd = 1'b0, exp_to = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 1'b0; prev_ack = 1'b0; prev_id = 1'b0; prev_dd = 1'b0;
      exp_to = 1'b0; run = 0;
    end else begin
      check("strobe_excl", 32'(ren && wen), 0);
      check("addr_align", 32'(addr[1:0]), 0);
      if ((ren || wen) && !prev_stb) check("strobe_vs_ack", 32'(prev_ack), 0);
      check("timeout_flag", 32'(timeout_seen), 32'(exp_to));
      check("done_width", 32'((i_done && prev_id) || (d_done && prev_dd)), 0);
      if ((ren || wen) && !ack) run++; else run = 0;
      check("wd_run", 32'(run > TO), 0);
      if (run == TO) exp_to = 1'b1;
      if (d_done) d_done_cnt++;
      if (i_done) i_done_cnt++;
      if (ren || wen) stb_cnt++;
      prev_stb = ren || wen; prev_ack = ack; prev_id = i_done; prev_dd = d_done;
    end
  end

  task automatic data_txn(input bit we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    logic [3:0]  w;
    logic [31:0] exp;
    bit ok;
    w = a[5:2];
    exp = refmem[w];
    ok = 1'b0;
    cyc = 0;
    d_we = we; d_be = be; d_addr = a; d_wdata = wd; d_req = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk); #1;
      cyc = k + 1;
      if (d_done) ok = 1'b1;
    end
    rd = d_rdata;
    d_ops++;
    check("d_complete", 32'(ok), 1);
    if (ok && !we) check("d_rdata", rd, exp);
    if (ok && we) refmem[w] = apply_store(refmem[w], wd, be);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic fetch_txn(input logic [31:0] a);
    logic [3:0] w;
    bit ok;
    w = a[5:2];
    ok = 1'b0;
    i_addr = a; i_req = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk); #1;
      if (i_done) ok = 1'b1;
    end
    i_ops++;
    check("i_complete", 32'(ok), 1);
    if (ok) check("i_rdata", i_rdata, refmem[w]);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic data_rand();
    logic [31:0] a, rd;
    logic [3:0] be;
    int sel, cyc;
    a = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    sel = $urandom_range(0, 3);
    be = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
    data_txn(1'($urandom_range(0, 1)), be, a, $urandom, rd, cyc);
  endtask

  task automatic fetch_rand();
    fetch_txn(($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(8, 15)) << 2));
  endtask

  initial begin
    #500_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int cyc, base_d, base_s, hi, lo, gap;
    bit do_d, do_i;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      refmem[i] = mem[i];
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", addr, 0);
    check("rst_data_i", data_i, 0);
    check("rst_strobes", 32'({ren, wen}), 0);
    check("rst_dones", 32'({i_done, d_done}), 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_timeout", 32'(timeout_seen), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word load with fixed interpreter latency of 3.
    lat_lo = 3; lat_hi = 3;
    mem[1] = 32'hDEADBEEF; refmem[1] = 32'hDEADBEEF;
    fork
      data_txn(1'b0, 4'h0, 32'h0000_0104, 32'h0, rd, cyc);
      begin
        @(posedge clk); #1;
        check("load_ren_next", 32'(ren), 1);
        check("load_addr", addr, 32'h0000_0104);
      end
    join
    check("load_rdata_lit", rd, 32'hDEADBEEF);
    check("load_latency", 32'(cyc), 5);
    lat_lo = 0; lat_hi = 4;

    // Simultaneous requests: the full-word store goes downstream first.
    log_q.delete();
    fork
      data_txn(1'b1, 4'hF, 32'h8000_0010, 32'h1234_5678, rd, cyc);
      fetch_txn(32'h0000_0020);
    join
    check("prio_count", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      check("prio_first_we", 32'(log_q[0].we), 1);
      check("prio_first_addr", log_q[0].a, 32'h8000_0010);
      check("prio_first_data", log_q[0].d, 32'h1234_5678);
      check("prio_second_rd", 32'(log_q[1].we), 0);
      check("prio_second_addr", log_q[1].a, 32'h0000_0020);
    end

    // Partial store onto 0x11223344.
    mem[2] = 32'h1122_3344; refmem[2] = 32'h1122_3344;
    log_q.delete();
    base_d = d_done_cnt;
    data_txn(1'b1, 4'b0010, 32'h0000_0008, 32'h0000_AB00, rd, cyc);
    repeat (3) @(posedge clk);
    #1;
    check("partial_done_once", 32'(d_done_cnt - base_d), 1);
`ifdef ARB_RMW_EN
    check("partial_count", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      check("partial_read_first", 32'(log_q[0].we), 0);
      check("partial_write_data", log_q[1].d, 32'h1122_AB44);
    end
`else
    check("partial_count", 32'(log_q.size()), 1);
    if (log_q.size() == 1) check("partial_write_data", log_q[0].d, 32'h0000_AB00);
`endif

    // Empty byte-enable store: done after one cycle, no downstream access.
    log_q.delete();
    base_s = stb_cnt;
    data_txn(1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, rd, cyc);
    check("be0_latency", 32'(cyc), 1);
    check("be0_no_access", 32'(log_q.size()), 0);
    check("be0_no_strobe", 32'(stb_cnt - base_s), 0);

    // Watchdog: no ack until after the first reissue.
    no_ack = 1'b1;
    fork
      data_txn(1'b0, 4'h0, 32'h0000_000C, 32'h0, rd, cyc);
      begin
        @(posedge clk); #1;
        check("to_ren_up", 32'(ren), 1);
        hi = 0;
        while (ren && hi < 50) begin hi++; @(posedge clk); #1; end
        check("to_high_cycles", 32'(hi), TO);
        lo = 0;
        while (!ren && lo < 50) begin lo++; @(posedge clk); #1; end
        check("to_gap_cycles", 32'(lo), GAP);
        check("to_reissue_addr", addr, 32'h0000_000C);
        check("to_sticky", 32'(timeout_seen), 1);
        no_ack = 1'b0;
      end
    join

    // Reset in the middle of an unacked read.
    no_ack = 1'b1;
    d_we = 1'b0; d_addr = 32'h0000_0018; d_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_ren_high", 32'(ren), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ren_async", 32'(ren), 0);
    check("mid_no_done", 32'(d_done), 0);
    check("mid_timeout_clr", 32'(timeout_seen), 0);
    d_req = 1'b0;
    no_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_no_done_later", 32'(d_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      do_d = ($urandom_range(0, 3) != 0);
      do_i = ($urandom_range(0, 2) == 0);
      fork
        begin if (do_d) data_rand(); end
        begin if (do_i) fetch_rand(); end
      join
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], refmem[i]);
    check("d_done_total", 32'(d_done_cnt), 32'(d_ops));
    check("i_done_total", 32'(i_done_cnt), 32'(i_ops));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
